// File: rtl/xgmii_lpbk_pkg.sv
// Shared XGMII loopback definitions: control characters, input FSM states
// and an idle-word builder sized by lane count.
package xgmii_lpbk_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SOP,
    S_DATA
  } frm_state_e;

  // Idle characters in the low `lanes` bytes, zero above.
  function automatic logic [63:0] idle_word(input int lanes);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i < lanes) w[8*i +: 8] = XGMII_IDLE;
    return w;
  endfunction

endpackage

// File: rtl/xgmii_lpbk_chan_delay_line.sv
// Circular delay buffer of {valid, txc, txd} words.
//   clk, rst         : clock, synchronous active-high clear of valid bits/pointer
//   delay            : extra latency in words; 0 bypasses the buffer
//   wr_txd/wr_txc    : word entering every cycle
//   rd_vld/rd_txd/rd_txc : registered output; rd_vld=0 means the slot was never written
module xgmii_delay_line #(
  parameter int DATA_W    = 64,
  parameter int LANES     = DATA_W / 8,
  parameter int MAX_DELAY = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(MAX_DELAY)-1:0] delay,
  input  logic [DATA_W-1:0]            wr_txd,
  input  logic [LANES-1:0]             wr_txc,
  output logic                         rd_vld,
  output logic [DATA_W-1:0]            rd_txd,
  output logic [LANES-1:0]             rd_txc
);
  localparam int AW = $clog2(MAX_DELAY);

  logic [MAX_DELAY-1:0] vld_q;
  logic [DATA_W-1:0]    txd_mem [MAX_DELAY];
  logic [LANES-1:0]     txc_mem [MAX_DELAY];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  // The word written D cycles ago sits D slots behind the write pointer.
  assign rd_ptr = wr_ptr - delay;

  always_ff @(posedge clk) begin
    txd_mem[wr_ptr] <= wr_txd;
    txc_mem[wr_ptr] <= wr_txc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_vld <= 1'b0;
      rd_txd <= '0;
      rd_txc <= '0;
    end else begin
      vld_q[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + 1'b1;
      // D=0 must forward this cycle's word; the slot at wr_ptr is being overwritten.
      if (delay == '0) begin
        rd_vld <= 1'b1;
        rd_txd <= wr_txd;
        rd_txc <= wr_txc;
      end else begin
        rd_vld <= vld_q[rd_ptr];
        rd_txd <= txd_mem[rd_ptr];
        rd_txc <= txc_mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/xgmii_lpbk_chan.sv
// XGMII loopback channel: MAC TX -> MAC RX with programmable latency,
// periodic error injection and frame statistics.
//   clk_156m25, reset_156m25 : clock, synchronous active-high reset
//   cfg_en / cfg_delay       : pass-through enable, extra latency in words
//   cfg_err_period           : corrupt every Nth frame, 0 = never
//   stat_clr                 : clears both statistics counters
//   xgmii_txd/txc            : from MAC TX
//   xgmii_rxd/rxc            : to MAC RX
//   stat_frames/stat_injected: saturating SOP / corrupted-frame counts
//   flushing                 : output forced IDLE after a config change
module xgmii_lpbk_chan
  import xgmii_lpbk_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_DELAY = 16,
  parameter int CNT_W     = 32
) (
  input  logic                         clk_156m25,
  input  logic                         reset_156m25,
  input  logic                         cfg_en,
  input  logic [$clog2(MAX_DELAY)-1:0] cfg_delay,
  input  logic [15:0]                  cfg_err_period,
  input  logic                         stat_clr,
  input  logic [DATA_W-1:0]            xgmii_txd,
  input  logic [DATA_W/8-1:0]          xgmii_txc,
  output logic [DATA_W-1:0]            xgmii_rxd,
  output logic [DATA_W/8-1:0]          xgmii_rxc,
  output logic [CNT_W-1:0]             stat_frames,
  output logic [CNT_W-1:0]             stat_injected,
  output logic                         flushing
);
  localparam int LANES   = DATA_W / 8;
  localparam int AW      = $clog2(MAX_DELAY);
  localparam int HI_LANE = (LANES == 8) ? 4 : 0;
  localparam logic [63:0]        IDLE_FULL = idle_word(LANES);
  localparam logic [DATA_W-1:0]  IDLE_D    = IDLE_FULL[DATA_W-1:0];
  // Lanes strictly after the SOP lane, for same-word TERM detection.
  localparam logic [LANES-1:0]   MASK_LO   = ~LANES'(1);
  localparam logic [LANES-1:0]   MASK_HI   = ~LANES'((1 << (HI_LANE + 1)) - 1);

  // ---- lane decode
  logic [LANES-1:0] is_start, is_term;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign is_start[i] = xgmii_txc[i] && (xgmii_txd[8*i +: 8] == XGMII_START);
    assign is_term[i]  = xgmii_txc[i] && (xgmii_txd[8*i +: 8] == XGMII_TERM);
  end

  logic sop_lo, sop_hi, sop, eop, sop_eop;
  assign sop_lo  = is_start[0];
  assign sop_hi  = (LANES == 8) && is_start[HI_LANE];
  assign sop     = sop_lo || sop_hi;
  assign eop     = |is_term;
  assign sop_eop = sop_lo ? |(is_term & MASK_LO) : |(is_term & MASK_HI);

  // ---- input FSM + injector (ahead of the delay line)
  frm_state_e  state, state_n;
  logic        inject_pend, pend_n;
  logic [15:0] frame_idx, idx_n;
  logic [15:0] period_q;
  logic        do_inj, frame_inc;
  logic [DATA_W-1:0] wr_txd;
  logic [LANES-1:0]  wr_txc;

  always_comb begin
    state_n   = state;
    pend_n    = inject_pend;
    idx_n     = frame_idx;
    do_inj    = 1'b0;
    frame_inc = 1'b0;
    if (sop) begin
      // A SOP always starts a new frame, even mid-frame.
      idx_n     = frame_idx + 16'd1;
      frame_inc = 1'b1;
      if (sop_eop) begin
        state_n = S_IDLE;
        pend_n  = 1'b0;
      end else begin
        state_n = S_SOP;
        pend_n  = (cfg_err_period != 16'd0) && ((idx_n % cfg_err_period) == 16'd0);
      end
    end else begin
      case (state)
        S_SOP: begin
          state_n = eop ? S_IDLE : S_DATA;
          pend_n  = 1'b0;
          // Only a pure data word can take the error character.
          do_inj  = inject_pend && (xgmii_txc == '0);
        end
        S_DATA:  if (eop) state_n = S_IDLE;
        default: ;
      endcase
    end
    if (cfg_err_period != period_q) idx_n = '0;
  end

  always_comb begin
    wr_txd = xgmii_txd;
    wr_txc = xgmii_txc;
    if (do_inj) begin
      wr_txd[7:0] = XGMII_ERROR;
      wr_txc[0]   = 1'b1;
    end
  end

  // ---- config tracking and flush
  logic          en_q;
  logic [AW-1:0] delay_q;
  logic [AW:0]   flush_cnt;
  logic          cfg_chg;

  assign cfg_chg  = (cfg_delay != delay_q) || (cfg_en != en_q);
  assign flushing = (flush_cnt != '0);

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state       <= S_IDLE;
      inject_pend <= 1'b0;
      frame_idx   <= '0;
      flush_cnt   <= '0;
      // Capture the live config so leaving reset does not look like a change.
      period_q    <= cfg_err_period;
      en_q        <= cfg_en;
      delay_q     <= cfg_delay;
    end else begin
      state       <= state_n;
      inject_pend <= pend_n;
      frame_idx   <= idx_n;
      period_q    <= cfg_err_period;
      en_q        <= cfg_en;
      delay_q     <= cfg_delay;
      if (cfg_chg)
        flush_cnt <= {1'b0, cfg_delay} + (AW+1)'(1);
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // ---- statistics (clear wins over increment)
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25 || stat_clr) begin
      stat_frames   <= '0;
      stat_injected <= '0;
    end else begin
      if (frame_inc && (stat_frames != '1))  stat_frames   <= stat_frames + 1'b1;
      if (do_inj && (stat_injected != '1))   stat_injected <= stat_injected + 1'b1;
    end
  end

  // ---- delay line and output mux
  logic              rd_vld;
  logic [DATA_W-1:0] rd_txd;
  logic [LANES-1:0]  rd_txc;

  xgmii_delay_line #(
    .DATA_W    (DATA_W),
    .LANES     (LANES),
    .MAX_DELAY (MAX_DELAY)
  ) u_dly (
    .clk    (clk_156m25),
    .rst    (reset_156m25),
    .delay  (cfg_delay),
    .wr_txd (wr_txd),
    .wr_txc (wr_txc),
    .rd_vld (rd_vld),
    .rd_txd (rd_txd),
    .rd_txc (rd_txc)
  );

  logic pass;
  assign pass      = en_q && !flushing && rd_vld;
  assign xgmii_rxd = pass ? rd_txd : IDLE_D;
  assign xgmii_rxc = pass ? rd_txc : '1;

endmodule
